// File: rtl/alu_issue_sched.sv
// alu_issue_sched: reservation station in front of the single-cycle ALU.
// It buffers dispatched ops and wakes waiting operands from the ALU (cdb0) and LSB (cdb1)
// result buses. Each cycle it issues at most one ready entry.
// Optional macro ALU_RS_AGE_EN: strict oldest-first selection using per-entry age counters.
// When that macro is undefined, the lowest ready index issues first.
`ifndef ROB_WIDTH
`define ROB_WIDTH 4
`endif

module alu_issue_sched #(
  parameter int unsigned RS_DEPTH = 8,
  parameter int unsigned IDX_W    = 3
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  clear,
  input  logic                  disp_valid,
  input  logic [8:0]            disp_op,
  input  logic [`ROB_WIDTH-1:0] disp_rob_id,
  input  logic [31:0]           disp_vj,
  input  logic [31:0]           disp_vk,
  input  logic [`ROB_WIDTH-1:0] disp_qj,
  input  logic [`ROB_WIDTH-1:0] disp_qk,
  input  logic                  disp_qj_busy,
  input  logic                  disp_qk_busy,
  output logic                  full,
  input  logic                  cdb0_valid,
  input  logic [`ROB_WIDTH-1:0] cdb0_rob_id,
  input  logic [31:0]           cdb0_value,
  input  logic                  cdb1_valid,
  input  logic [`ROB_WIDTH-1:0] cdb1_rob_id,
  input  logic [31:0]           cdb1_value,
  output logic                  calc_enable,
  output logic [31:0]           lhs,
  output logic [31:0]           rhs,
  output logic [8:0]            op,
  output logic [`ROB_WIDTH-1:0] rob_dep
);
  localparam int unsigned ROB_W = `ROB_WIDTH;

  logic [RS_DEPTH-1:0]            valid_q, valid_d;
  logic [RS_DEPTH-1:0]            qj_busy_q, qj_busy_d, qk_busy_q, qk_busy_d;
  logic [RS_DEPTH-1:0][8:0]       op_q, op_d;
  logic [RS_DEPTH-1:0][ROB_W-1:0] rob_q, rob_d, qj_q, qj_d, qk_q, qk_d;
  logic [RS_DEPTH-1:0][31:0]      vj_q, vj_d, vk_q, vk_d;
  logic                           calc_en_q, calc_en_d;
  logic [31:0]                    lhs_q, lhs_d, rhs_q, rhs_d;
  logic [8:0]                     op_out_q, op_out_d;
  logic [ROB_W-1:0]               rob_dep_q, rob_dep_d;

  logic [RS_DEPTH-1:0] ready;
  logic                any_ready, sel_found, free_found, do_disp;
  logic [IDX_W-1:0]    sel_idx, free_idx;
  logic [32:0]         snp;
`ifdef ALU_RS_AGE_EN
  logic [RS_DEPTH-1:0][IDX_W-1:0] age_q, age_d;
  logic [IDX_W-1:0]               sel_age, age_tmp;
`endif

  // Returns {hit, value}; cdb0 wins if both buses carry the same tag.
  function automatic logic [32:0] cdb_snoop(
    input logic [ROB_W-1:0] tag,
    input logic v0, input logic [ROB_W-1:0] t0, input logic [31:0] d0,
    input logic v1, input logic [ROB_W-1:0] t1, input logic [31:0] d1);
    if (v0 && t0 == tag) return {1'b1, d0};
    if (v1 && t1 == tag) return {1'b1, d1};
    return {1'b0, 32'h0};
  endfunction

  assign full        = &valid_q;
  assign calc_enable = calc_en_q;
  assign lhs         = lhs_q;
  assign rhs         = rhs_q;
  assign op          = op_out_q;
  assign rob_dep     = rob_dep_q;

  // Ready vector, issue selection and lowest free slot, all from registered state.
  always_comb begin
    ready      = valid_q & ~qj_busy_q & ~qk_busy_q;
    any_ready  = |ready;
    sel_idx    = '0;
    sel_found  = 1'b0;
    free_idx   = '0;
    free_found = 1'b0;
`ifdef ALU_RS_AGE_EN
    sel_age    = '0;
`endif
    for (int unsigned i = 0; i < RS_DEPTH; i++) begin
`ifdef ALU_RS_AGE_EN
      if (ready[i] && (!sel_found || age_q[i] > sel_age)) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
        sel_age   = age_q[i];
      end
`else
      if (ready[i] && !sel_found) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
      end
`endif
      if (!valid_q[i] && !free_found) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  // Next state: clear beats everything; otherwise wakeup, issue and dispatch all happen together.
  always_comb begin
    valid_d   = valid_q;   qj_busy_d = qj_busy_q; qk_busy_d = qk_busy_q;
    op_d      = op_q;      rob_d     = rob_q;
    qj_d      = qj_q;      qk_d      = qk_q;
    vj_d      = vj_q;      vk_d      = vk_q;
    calc_en_d = calc_en_q; lhs_d     = lhs_q;     rhs_d = rhs_q;
    op_out_d  = op_out_q;  rob_dep_d = rob_dep_q;
    snp       = '0;
    do_disp   = disp_valid && !full;
`ifdef ALU_RS_AGE_EN
    age_d     = age_q;
    age_tmp   = '0;
`endif
    if (rdy_in) begin
      if (clear) begin
        valid_d   = '0;
        calc_en_d = 1'b0;
      end else begin
        for (int unsigned i = 0; i < RS_DEPTH; i++) begin
          if (qj_busy_q[i]) begin
            snp = cdb_snoop(qj_q[i], cdb0_valid, cdb0_rob_id, cdb0_value,
                            cdb1_valid, cdb1_rob_id, cdb1_value);
            if (snp[32]) begin
              vj_d[i]      = snp[31:0];
              qj_busy_d[i] = 1'b0;
            end
          end
          if (qk_busy_q[i]) begin
            snp = cdb_snoop(qk_q[i], cdb0_valid, cdb0_rob_id, cdb0_value,
                            cdb1_valid, cdb1_rob_id, cdb1_value);
            if (snp[32]) begin
              vk_d[i]      = snp[31:0];
              qk_busy_d[i] = 1'b0;
            end
          end
`ifdef ALU_RS_AGE_EN
          // Age = number of live younger entries: ages stay distinct and bounded by RS_DEPTH-1.
          if (valid_q[i]) begin
            age_tmp = age_q[i];
            if (any_ready && age_q[i] > sel_age) age_tmp = age_tmp - 1'b1;
            if (do_disp && age_tmp != '1)        age_tmp = age_tmp + 1'b1;
            age_d[i] = age_tmp;
          end
`endif
        end
        calc_en_d = any_ready;
        if (any_ready) begin
          lhs_d            = vj_q[sel_idx];
          rhs_d            = vk_q[sel_idx];
          op_out_d         = op_q[sel_idx];
          rob_dep_d        = rob_q[sel_idx];
          valid_d[sel_idx] = 1'b0;
        end
        if (do_disp) begin
          valid_d[free_idx]   = 1'b1;
          op_d[free_idx]      = disp_op;
          rob_d[free_idx]     = disp_rob_id;
          qj_d[free_idx]      = disp_qj;
          qk_d[free_idx]      = disp_qk;
          vj_d[free_idx]      = disp_vj;
          vk_d[free_idx]      = disp_vk;
          qj_busy_d[free_idx] = disp_qj_busy;
          qk_busy_d[free_idx] = disp_qk_busy;
`ifdef ALU_RS_AGE_EN
          age_d[free_idx]     = '0;
`endif
          if (disp_qj_busy) begin
            snp = cdb_snoop(disp_qj, cdb0_valid, cdb0_rob_id, cdb0_value,
                            cdb1_valid, cdb1_rob_id, cdb1_value);
            if (snp[32]) begin
              vj_d[free_idx]      = snp[31:0];
              qj_busy_d[free_idx] = 1'b0;
            end
          end
          if (disp_qk_busy) begin
            snp = cdb_snoop(disp_qk, cdb0_valid, cdb0_rob_id, cdb0_value,
                            cdb1_valid, cdb1_rob_id, cdb1_value);
            if (snp[32]) begin
              vk_d[free_idx]      = snp[31:0];
              qk_busy_d[free_idx] = 1'b0;
            end
          end
        end
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      valid_q   <= '0; qj_busy_q <= '0; qk_busy_q <= '0;
      op_q      <= '0; rob_q     <= '0; qj_q      <= '0; qk_q <= '0;
      vj_q      <= '0; vk_q      <= '0;
      calc_en_q <= 1'b0; lhs_q <= '0; rhs_q <= '0; op_out_q <= '0; rob_dep_q <= '0;
`ifdef ALU_RS_AGE_EN
      age_q     <= '0;
`endif
    end else begin
      valid_q   <= valid_d; qj_busy_q <= qj_busy_d; qk_busy_q <= qk_busy_d;
      op_q      <= op_d;    rob_q     <= rob_d;     qj_q      <= qj_d; qk_q <= qk_d;
      vj_q      <= vj_d;    vk_q      <= vk_d;
      calc_en_q <= calc_en_d; lhs_q <= lhs_d; rhs_q <= rhs_d;
      op_out_q  <= op_out_d;  rob_dep_q <= rob_dep_d;
`ifdef ALU_RS_AGE_EN
      age_q     <= age_d;
`endif
    end
  end

endmodule
